rc4_key_search_ctrl: RTL and testbench

//  Top-level scheduler for the RC4 brute-force datapath. For each candidate key it sequences
//  S-init -> KSA shuffle -> decryption, owns the single S-memory port and muxes it to the

---
 rtl/rc4_key_search_ctrl.sv | 158 +++++++++++++++
 tb/tb_rc4_key_search_ctrl.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rc4_key_search_ctrl.sv
// rc4_key_search_ctrl: RC4 brute-force key search scheduler.
// For each candidate key this block runs S-init, then the KSA shuffle, then decryption.
// It owns the single S-memory port and screens decrypted bytes as they arrive.
module rc4_key_search_ctrl #(
  parameter int unsigned          KEY_WIDTH  = 24,
  parameter logic [KEY_WIDTH-1:0] KEY_LAST   = KEY_WIDTH'(24'h3F_FFFF),
  parameter int unsigned          MSG_DEP    = 32,
  parameter int unsigned          ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [KEY_WIDTH-1:0]  key_first,
  output logic [KEY_WIDTH-1:0]  key,
  output logic                  init_start,
  input  logic                  init_done,
  output logic                  shuf_start,
  input  logic                  shuf_done,
  output logic                  dec_start,
  output logic                  dec_abort,
  input  logic                  dec_done,
  input  logic                  dec_valid,
  input  logic [7:0]            dec_byte,
  input  logic [ADDR_WIDTH-1:0] init_addr,
  input  logic [7:0]            init_wdata,
  input  logic                  init_wren,
  input  logic [ADDR_WIDTH-1:0] shuf_addr,
  input  logic [7:0]            shuf_wdata,
  input  logic                  shuf_wren,
  input  logic [ADDR_WIDTH-1:0] dec_addr,
  input  logic [7:0]            dec_wdata,
  input  logic                  dec_wren,
  output logic [ADDR_WIDTH-1:0] s_addr,
  output logic [7:0]            s_wdata,
  output logic                  s_wren,
  output logic                  busy,
  output logic                  found,
  output logic                  exhausted
);

  // Counter saturates one past MSG_DEP so a chatty decryptor can never wrap back to a match.
  localparam int unsigned       CNT_W   = $clog2(MSG_DEP + 2);
  localparam logic [CNT_W-1:0]  CNT_SAT = CNT_W'(MSG_DEP + 1);
  localparam logic [CNT_W-1:0]  CNT_END = CNT_W'(MSG_DEP);

  typedef enum logic [3:0] {
    S_IDLE, S_INIT, S_INIT_WAIT, S_SHUF, S_SHUF_WAIT,
    S_DEC, S_DEC_WAIT, S_NEXT_KEY, S_FOUND, S_EXHAUSTED
  } state_t;

  state_t               state, state_d;
  logic [KEY_WIDTH-1:0] key_d;
  logic [CNT_W-1:0]     cnt, cnt_d, cnt_new;
  logic                 abort_d;
  logic                 byte_ok;

  // Printable screen: lowercase letters or space.
  assign byte_ok = ((dec_byte >= 8'h61) && (dec_byte <= 8'h7A)) || (dec_byte == 8'h20);

  // Byte count including any byte arriving this cycle.
  assign cnt_new = (dec_valid && (cnt != CNT_SAT)) ? cnt + CNT_W'(1) : cnt;

  // Next-state, key and counter logic.
  always_comb begin
    state_d = state;
    key_d   = key;
    cnt_d   = cnt;
    abort_d = 1'b0;
    case (state)
      S_IDLE, S_FOUND, S_EXHAUSTED: begin
        if (start) begin
          state_d = S_INIT;
          key_d   = key_first;
        end
      end
      S_INIT:      state_d = S_INIT_WAIT;
      S_INIT_WAIT: if (init_done) state_d = S_SHUF;
      S_SHUF:      state_d = S_SHUF_WAIT;
      S_SHUF_WAIT: if (shuf_done) state_d = S_DEC;
      S_DEC: begin
        cnt_d   = '0;
        state_d = S_DEC_WAIT;
      end
      S_DEC_WAIT: begin
        cnt_d = cnt_new;
        if (dec_valid && !byte_ok) begin
          state_d = S_NEXT_KEY;
          abort_d = 1'b1;
        end else if (dec_done) begin
          state_d = (cnt_new == CNT_END) ? S_FOUND : S_NEXT_KEY;
        end
      end
      S_NEXT_KEY: begin
        // Starting above KEY_LAST searches that single key only.
        if (key >= KEY_LAST) begin
          state_d = S_EXHAUSTED;
        end else begin
          key_d   = key + KEY_WIDTH'(1);
          state_d = S_INIT;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, key, counter and registered control outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      key        <= '0;
      cnt        <= '0;
      init_start <= 1'b0;
      shuf_start <= 1'b0;
      dec_start  <= 1'b0;
      dec_abort  <= 1'b0;
      busy       <= 1'b0;
      found      <= 1'b0;
      exhausted  <= 1'b0;
    end else begin
      state      <= state_d;
      key        <= key_d;
      cnt        <= cnt_d;
      init_start <= (state_d == S_INIT);
      shuf_start <= (state_d == S_SHUF);
      dec_start  <= (state_d == S_DEC);
      dec_abort  <= abort_d;
      busy       <= !((state_d == S_IDLE) || (state_d == S_FOUND) || (state_d == S_EXHAUSTED));
      found      <= (state_d == S_FOUND);
      exhausted  <= (state_d == S_EXHAUSTED);
    end
  end

  // S-memory port goes to whichever phase owns the current state; idle otherwise.
  always_comb begin
    s_addr  = '0;
    s_wdata = '0;
    s_wren  = 1'b0;
    case (state)
      S_INIT, S_INIT_WAIT: begin
        s_addr  = init_addr;
        s_wdata = init_wdata;
        s_wren  = init_wren;
      end
      S_SHUF, S_SHUF_WAIT: begin
        s_addr  = shuf_addr;
        s_wdata = shuf_wdata;
        s_wren  = shuf_wren;
      end
      S_DEC, S_DEC_WAIT: begin
        s_addr  = dec_addr;
        s_wdata = dec_wdata;
        s_wren  = dec_wren;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_rc4_key_search_ctrl.sv
// tb_rc4_key_search_ctrl: directed bench for the RC4 key search scheduler.
module tb_rc4_key_search_ctrl;

  localparam int unsigned KW = 24;
  localparam int unsigned AW = 8;
  localparam int unsigned MD = 32;
  localparam logic [KW-1:0] KL = 24'h3F_FFFF;

  logic          clk, reset_n, start;
  logic [KW-1:0] key_first, key;
  logic          init_start, init_done, shuf_start, shuf_done;
  logic          dec_start, dec_abort, dec_done, dec_valid;
  logic [7:0]    dec_byte;
  logic [AW-1:0] init_addr, shuf_addr, dec_addr, s_addr;
  logic [7:0]    init_wdata, shuf_wdata, dec_wdata, s_wdata;
  logic          init_wren, shuf_wren, dec_wren, s_wren;
  logic          busy, found, exhausted;

  int n_cmp = 0;
  int n_err = 0;
  int n_init = 0;
  int n_abort = 0;

  rc4_key_search_ctrl #(
    .KEY_WIDTH(KW), .KEY_LAST(KL), .MSG_DEP(MD), .ADDR_WIDTH(AW)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .key_first(key_first), .key(key),
    .init_start(init_start), .init_done(init_done),
    .shuf_start(shuf_start), .shuf_done(shuf_done),
    .dec_start(dec_start), .dec_abort(dec_abort), .dec_done(dec_done),
    .dec_valid(dec_valid), .dec_byte(dec_byte),
    .init_addr(init_addr), .init_wdata(init_wdata), .init_wren(init_wren),
    .shuf_addr(shuf_addr), .shuf_wdata(shuf_wdata), .shuf_wren(shuf_wren),
    .dec_addr(dec_addr), .dec_wdata(dec_wdata), .dec_wren(dec_wren),
    .s_addr(s_addr), .s_wdata(s_wdata), .s_wren(s_wren),
    .busy(busy), .found(found), .exhausted(exhausted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse-cycle counters, sampled mid-cycle.
  always @(negedge clk) begin
    if (init_start) n_init++;
    if (dec_abort)  n_abort++;
  end

  typedef struct {
    logic [7:0] b;
    logic       ab;
  } vec_t;

  vec_t vt [11];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Bounded wait for a start pulse: 0 init, 1 shuf, 2 dec.
  task automatic wait_sig(input int sel);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < 50; i++) begin
      hit = (sel == 0) ? init_start : (sel == 1) ? shuf_start : dec_start;
      if (hit) break;
      tick();
    end
    n_cmp++;
    if (!hit) begin
      n_err++;
      $display("FAIL wait_start%0d: got timeout expected pulse", sel);
    end
  endtask

  task automatic do_start(input logic [KW-1:0] kf);
    key_first = kf;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // From a pending init_start, run both setup phases and land in DEC_WAIT.
  task automatic to_dec_wait();
    wait_sig(0);
    init_done = 1'b1;
    wait_sig(1);
    init_done = 1'b0;
    shuf_done = 1'b1;
    wait_sig(2);
    shuf_done = 1'b0;
    tick();
  endtask

  task automatic send(input logic v, input logic [7:0] b, input logic d);
    dec_valid = v;
    dec_byte  = b;
    dec_done  = d;
    tick();
    dec_valid = 1'b0;
    dec_done  = 1'b0;
    dec_byte  = 8'h00;
  endtask

  // Plaintext for the "correct" key: lowercase letters with spaces.
  function automatic logic [7:0] txt(input int i);
    logic [7:0] c;
    c = (i % 7 == 6) ? 8'h20 : 8'h61 + 8'(i % 26);
    return c;
  endfunction

  initial begin
    int base;
    vt = '{'{8'h41, 1'b1}, '{8'h61, 1'b0}, '{8'h7A, 1'b0}, '{8'h60, 1'b1},
           '{8'h7B, 1'b1}, '{8'h20, 1'b0}, '{8'h1F, 1'b1}, '{8'h21, 1'b1},
           '{8'h00, 1'b1}, '{8'hFF, 1'b1}, '{8'h6D, 1'b0}};
    reset_n = 1'b0; start = 1'b0; key_first = '0;
    init_done = 1'b0; shuf_done = 1'b0; dec_done = 1'b0; dec_valid = 1'b0; dec_byte = '0;
    init_addr = 8'h5A; init_wdata = 8'h33; init_wren = 1'b1;
    shuf_addr = 8'h11; shuf_wdata = 8'h44; shuf_wren = 1'b1;
    dec_addr  = 8'h22; dec_wdata  = 8'h55; dec_wren  = 1'b1;
    tick(); tick();
    reset_n = 1'b1;
    tick();

    // Reset / idle state with every requester asking to write.
    chk("rst_key", 32'(key), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_found", 32'(found), 32'h0);
    chk("rst_exh", 32'(exhausted), 32'h0);
    chk("rst_init_start", 32'(init_start), 32'h0);
    chk("rst_s_wren", 32'(s_wren), 32'h0);
    chk("rst_s_addr", 32'(s_addr), 32'h0);

    // Mux ownership during INIT_WAIT, start-while-busy, then reset in SHUF_WAIT.
    init_wren = 1'b0;
    do_start(24'h000055);
    wait_sig(0);
    tick();
    chk("initw_s_wren_off", 32'(s_wren), 32'h0);
    chk("initw_s_addr", 32'(s_addr), 32'h5A);
    chk("initw_s_wdata", 32'(s_wdata), 32'h33);
    init_wren = 1'b1;
    #1;
    chk("initw_s_wren_on", 32'(s_wren), 32'h1);
    base = n_init;
    do_start(24'h000000);
    chk("busy_start_key", 32'(key), 32'h55);
    chk("busy_start_busy", 32'(busy), 32'h1);
    init_done = 1'b1;
    wait_sig(1);
    init_done = 1'b0;
    chk("busy_start_no_init", 32'(n_init), 32'(base));
    chk("shuf_s_addr", 32'(s_addr), 32'h11);
    shuf_wren = 1'b0;
    #1;
    chk("shuf_s_wren_off", 32'(s_wren), 32'h0);
    tick();
    shuf_wren = 1'b1;
    #1;
    chk("shufw_s_wren_on", 32'(s_wren), 32'h1);
    reset_n = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 32'h0);
    chk("arst_s_wren", 32'(s_wren), 32'h0);
    chk("arst_key", 32'(key), 32'h0);
    base = n_init;
    tick(); tick();
    reset_n = 1'b1;
    shuf_done = 1'b1; init_done = 1'b1; dec_done = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    shuf_done = 1'b0; init_done = 1'b0; dec_done = 1'b0;
    chk("arst_no_pulse", 32'(n_init), 32'(base));
    chk("arst_idle_busy", 32'(busy), 32'h0);
    chk("arst_idle_s_wren", 32'(s_wren), 32'h0);

    // Search from 0x10; only key 0x12 decrypts to valid text.
    base = n_init;
    do_start(24'h000010);
    for (int k = 16; k <= 18; k++) begin
      to_dec_wait();
      chk("srch_key", 32'(key), 32'(k));
      chk("srch_dec_mux", 32'(s_addr), 32'h22);
      if (k == 18) begin
        for (int i = 0; i < 32; i++) send(1'b1, txt(i), (i == 31));
        chk("srch_found", 32'(found), 32'h1);
      end else begin
        send(1'b1, 8'h41, 1'b0);
        chk("srch_abort", 32'(dec_abort), 32'h1);
        chk("srch_busy", 32'(busy), 32'h1);
        if (k == 16) begin
          tick();
          chk("abort_1cyc", 32'(dec_abort), 32'h0);
          chk("abort_next_init", 32'(init_start), 32'h1);
          chk("abort_next_key", 32'(key), 32'h11);
        end
      end
    end
    tick();
    chk("found_hold", 32'(found), 32'h1);
    chk("found_busy", 32'(busy), 32'h0);
    chk("found_key", 32'(key), 32'h12);
    chk("found_inits", 32'(n_init - base), 32'd3);
    chk("found_s_wren", 32'(s_wren), 32'h0);

    // Screening table: first byte decides abort; KEY_LAST start ends in EXHAUSTED.
    foreach (vt[j]) begin
      base = n_init;
      do_start(KL);
      to_dec_wait();
      send(1'b1, vt[j].b, 1'b0);
      chk($sformatf("scr_abort_%02h", vt[j].b), 32'(dec_abort), 32'(vt[j].ab));
      if (!vt[j].ab) begin
        send(1'b0, 8'h00, 1'b1);
        chk($sformatf("scr_short_%02h", vt[j].b), 32'(dec_abort), 32'h0);
      end
      tick();
      chk("exh_flag", 32'(exhausted), 32'h1);
      chk("exh_busy", 32'(busy), 32'h0);
      chk("exh_key", 32'(key), 32'(KL));
      tick(); tick(); tick();
      chk("exh_inits", 32'(n_init - base), 32'd1);
    end

    // Invalid byte together with dec_done: abort wins.
    do_start(KL);
    to_dec_wait();
    for (int i = 0; i < 31; i++) send(1'b1, txt(i), 1'b0);
    send(1'b1, 8'h7B, 1'b1);
    chk("inv_done_abort", 32'(dec_abort), 32'h1);
    tick();
    chk("inv_done_found", 32'(found), 32'h0);
    chk("inv_done_exh", 32'(exhausted), 32'h1);

    // dec_done after 31 bytes: no match, no abort.
    do_start(KL);
    to_dec_wait();
    for (int i = 0; i < 31; i++) send(1'b1, txt(i), 1'b0);
    send(1'b0, 8'h00, 1'b1);
    chk("short_abort", 32'(dec_abort), 32'h0);
    tick();
    chk("short_found", 32'(found), 32'h0);

    // dec_done after 33 valid bytes: too many, no match.
    do_start(KL);
    to_dec_wait();
    for (int i = 0; i < 33; i++) send(1'b1, txt(i), 1'b0);
    send(1'b0, 8'h00, 1'b1);
    tick();
    chk("long_found", 32'(found), 32'h0);
    chk("long_exh", 32'(exhausted), 32'h1);

    // Exactly 32 valid bytes, dec_done on its own later cycle.
    base = n_abort;
    do_start(24'h000200);
    to_dec_wait();
    for (int i = 0; i < 32; i++) send(1'b1, txt(i), 1'b0);
    send(1'b0, 8'h00, 1'b1);
    chk("late_done_found", 32'(found), 32'h1);
    chk("late_done_key", 32'(key), 32'h200);
    chk("late_done_no_abort", 32'(n_abort - base), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
